// File: rtl/noise_pkg.sv
// Shared types and constants for the noise code sequencer.
// The LFSR helper is only exercised when NOISE_SEQ_LFSR_EN is defined.
package noise_pkg;

    localparam int NOISE_W = 16;

    typedef enum logic [1:0] {
        NOISE_MODE_STATIC = 2'd0,
        NOISE_MODE_SWEEP  = 2'd1,
        NOISE_MODE_LFSR   = 2'd2,
        NOISE_MODE_RSVD   = 2'd3
    } noise_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } noise_state_e;

    // Taps of x^16+x^14+x^13+x^11+1 as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr16_next(input logic [15:0] cur);
        return {cur[14:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/noise_lfsr16.sv
// 16-bit Fibonacci LFSR holding the code that follows the one currently on the output,
// so the sequencer can register it without a combinational step. Used under NOISE_SEQ_LFSR_EN.
module noise_lfsr16
    import noise_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        advance,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    // Look-ahead state: after load, q is the successor of the seed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 16'h0001;
        end else if (load) begin
            q <= lfsr16_next(seed);
        end else if (advance) begin
            q <= lfsr16_next(q);
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/noise_sweep_seq.sv
// Noise-selection code sequencer: static code, linear sweep, or (with NOISE_SEQ_LFSR_EN)
// a pseudo-random walk, each code held for a programmable dwell.
module noise_sweep_seq
    import noise_pkg::*;
#(
    parameter int NOISE_W = 16,
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [1:0]         mode,
    input  logic [NOISE_W-1:0] code_start,
    input  logic [NOISE_W-1:0] code_end,
    input  logic [NOISE_W-1:0] code_step,
    input  logic [DWELL_W-1:0] dwell,
    output logic               valid,
    output logic [NOISE_W-1:0] noise_data,
    output logic               busy,
    output logic               done
);

    localparam logic [NOISE_W-1:0] CODE_ZERO  = {NOISE_W{1'b0}};
    localparam logic [NOISE_W-1:0] CODE_ONE   = {{(NOISE_W-1){1'b0}}, 1'b1};
    localparam logic [DWELL_W-1:0] DWELL_ZERO = {DWELL_W{1'b0}};
    localparam logic [DWELL_W-1:0] DWELL_ONE  = {{(DWELL_W-1){1'b0}}, 1'b1};

    noise_state_e       state_r;
    noise_mode_e        mode_r;
    logic [NOISE_W-1:0] data_r;
    logic [NOISE_W-1:0] end_r;
    logic [NOISE_W-1:0] step_r;
    logic [DWELL_W-1:0] reload_r;
    logic [DWELL_W-1:0] cnt_r;
    logic               valid_r;
    logic               busy_r;
    logic               done_r;

    noise_mode_e        mode_s;
    logic [NOISE_W-1:0] start_code_s;
    logic [NOISE_W-1:0] step_eff_s;
    logic [DWELL_W-1:0] reload_s;
    logic [NOISE_W:0]   sweep_next_s;
    logic               sweep_last_s;
    logic [NOISE_W-1:0] lfsr_code_s;
    logic               expire_s;

    // Map the requested mode onto what this build implements; reserved codes act as STATIC
    always_comb begin
        mode_s       = NOISE_MODE_STATIC;
        start_code_s = code_start;
        case (mode)
            2'd1: mode_s = NOISE_MODE_SWEEP;
`ifdef NOISE_SEQ_LFSR_EN
            2'd2: begin
                mode_s = NOISE_MODE_LFSR;
                if (code_start == CODE_ZERO) begin
                    start_code_s = CODE_ONE;
                end else begin
                    start_code_s = code_start;
                end
            end
`endif
            default: mode_s = NOISE_MODE_STATIC;
        endcase
    end

    // Zero step and zero dwell both degrade to one
    always_comb begin
        if (code_step == CODE_ZERO) begin
            step_eff_s = CODE_ONE;
        end else begin
            step_eff_s = code_step;
        end
        if (dwell == DWELL_ZERO) begin
            reload_s = DWELL_ZERO;
        end else begin
            reload_s = dwell - DWELL_ONE;
        end
    end

    // Sweep successor computed one bit wider so a wrap past all-ones ends the sweep
    always_comb begin
        sweep_next_s = {1'b0, data_r} + {1'b0, step_r};
        if ((data_r == end_r) || (sweep_next_s > {1'b0, end_r}) || sweep_next_s[NOISE_W]) begin
            sweep_last_s = 1'b1;
        end else begin
            sweep_last_s = 1'b0;
        end
    end

    assign expire_s = (state_r == ST_RUN) && !abort && (cnt_r == DWELL_ZERO);

`ifdef NOISE_SEQ_LFSR_EN
    logic [15:0] lfsr_q_s;
    logic        lfsr_load_s;
    logic        lfsr_adv_s;

    assign lfsr_load_s = (state_r == ST_IDLE) && start && !abort;
    assign lfsr_adv_s  = expire_s && (mode_r == NOISE_MODE_LFSR);

    noise_lfsr16 u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (lfsr_load_s),
        .advance (lfsr_adv_s),
        .seed    (16'(start_code_s)),
        .q       (lfsr_q_s)
    );

    assign lfsr_code_s = NOISE_W'(lfsr_q_s);
`else
    assign lfsr_code_s = data_r;
`endif

    // Sequencer FSM with shadow configuration and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            mode_r   <= NOISE_MODE_STATIC;
            data_r   <= CODE_ZERO;
            end_r    <= CODE_ZERO;
            step_r   <= CODE_ZERO;
            reload_r <= DWELL_ZERO;
            cnt_r    <= DWELL_ZERO;
            valid_r  <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start && !abort) begin
                        mode_r   <= mode_s;
                        end_r    <= code_end;
                        step_r   <= step_eff_s;
                        reload_r <= reload_s;
                        cnt_r    <= reload_s;
                        data_r   <= start_code_s;
                        valid_r  <= 1'b1;
                        busy_r   <= 1'b1;
                        state_r  <= ST_RUN;
                    end else begin
                        valid_r <= 1'b0;
                        busy_r  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        state_r <= ST_IDLE;
                        valid_r <= 1'b0;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b0;
                    end else if (!expire_s) begin
                        cnt_r <= cnt_r - DWELL_ONE;
                    end else begin
                        cnt_r <= reload_r;
                        case (mode_r)
                            NOISE_MODE_SWEEP: begin
                                if (sweep_last_s) begin
                                    state_r <= ST_DONE;
                                    valid_r <= 1'b0;
                                    busy_r  <= 1'b0;
                                    done_r  <= 1'b1;
                                end else begin
                                    data_r <= sweep_next_s[NOISE_W-1:0];
                                end
                            end
                            NOISE_MODE_LFSR: data_r <= lfsr_code_s;
                            default:         data_r <= data_r;
                        endcase
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    valid_r <= 1'b0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    valid_r <= 1'b0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign valid      = valid_r;
    assign noise_data = data_r;
    assign busy       = busy_r;
    assign done       = done_r;

endmodule

// File: tb/tb_noise_sweep_seq.sv
// Self-checking bench for noise_sweep_seq; expected code streams are built from the sweep
// rules as queues. LFSR expectations follow NOISE_SEQ_LFSR_EN.
module tb_noise_sweep_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [15:0] code_start = 16'h0000;
    logic [15:0] code_end = 16'h0000;
    logic [15:0] code_step = 16'h0000;
    logic [15:0] dwell = 16'h0000;
    logic        valid;
    logic [15:0] noise_data;
    logic        busy;
    logic        done;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    noise_sweep_seq #(.NOISE_W(16), .DWELL_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .mode       (mode),
        .code_start (code_start),
        .code_end   (code_end),
        .code_step  (code_step),
        .dwell      (dwell),
        .valid      (valid),
        .noise_data (noise_data),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic v, input logic [15:0] d,
                             input logic b, input logic dn);
        check({tag, ".valid"}, {31'd0, valid}, {31'd0, v});
        check({tag, ".data"},  {16'd0, noise_data}, {16'd0, d});
        check({tag, ".busy"},  {31'd0, busy}, {31'd0, b});
        check({tag, ".done"},  {31'd0, done}, {31'd0, dn});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Build the expected per-cycle code list from the sweep rules, then run and compare
    task automatic run_sweep(input string tag, input logic [15:0] s, input logic [15:0] e,
                             input logic [15:0] st, input logic [15:0] dw, input bit disturb);
        logic [15:0] codes[$];
        logic [15:0] cyc[$];
        logic [16:0] cur;
        logic [16:0] nxt;
        logic [16:0] stp;
        logic [15:0] last;
        int hold;
        stp  = (st == 16'd0) ? 17'd1 : {1'b0, st};
        hold = (dw == 16'd0) ? 1 : int'(dw);
        cur  = {1'b0, s};
        for (int k = 0; k < 70000; k++) begin
            codes.push_back(cur[15:0]);
            nxt = cur + stp;
            if (cur[15:0] == e || nxt > {1'b0, e}) break;
            cur = nxt;
        end
        foreach (codes[k]) for (int h = 0; h < hold; h++) cyc.push_back(codes[k]);
        last = codes[codes.size()-1];

        mode = 2'd1; code_start = s; code_end = e; code_step = st; dwell = dw;
        start = 1'b1;
        step();
        start = 1'b0;
        foreach (cyc[i]) begin
            check_out($sformatf("%s.c%0d", tag, i), 1'b1, cyc[i], 1'b1, 1'b0);
            if (disturb && i == 2) begin
                start = 1'b1; code_end = 16'h0001; code_step = 16'h0007; mode = 2'd0;
            end
            step();
            start = 1'b0;
        end
        check_out({tag, ".done"}, 1'b0, last, 1'b0, 1'b1);
        step();
        check_out({tag, ".idle"}, 1'b0, last, 1'b0, 1'b0);
        step();
    endtask

    initial begin
        logic [15:0] lf;
        logic [15:0] rs;
        logic [15:0] re;

        // Reset state
        #2;
        check_out("reset", 1'b0, 16'h0000, 1'b0, 1'b0);
        step();
        rst_n = 1'b1;
        step();
        check_out("reset_idle", 1'b0, 16'h0000, 1'b0, 1'b0);

        // Directed sweeps
        run_sweep("sweep0_3", 16'h0000, 16'h0003, 16'h0001, 16'h0002, 1'b0);
        run_sweep("sweep_carry", 16'hFFF0, 16'hFFFF, 16'h0008, 16'h0001, 1'b0);
        run_sweep("sweep_disturb", 16'h0000, 16'h0003, 16'h0001, 16'h0002, 1'b1);
        run_sweep("sweep_rev", 16'h0010, 16'h0008, 16'h0001, 16'h0000, 1'b0);
        run_sweep("sweep_step0", 16'h0100, 16'h0104, 16'h0000, 16'h0001, 1'b0);

        // Randomized sweeps
        for (int r = 0; r < 6; r++) begin
            rs = 16'($urandom_range(0, 60000));
            re = rs + 16'($urandom_range(0, 30));
            run_sweep($sformatf("rnd%0d", r), rs, re, 16'($urandom_range(0, 4)),
                      16'($urandom_range(0, 3)), 1'b0);
        end

        // STATIC with abort, then reserved mode
        mode = 2'd0; code_start = 16'h00A5; dwell = 16'h0001;
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check_out($sformatf("static.c%0d", i), 1'b1, 16'h00A5, 1'b1, 1'b0);
            step();
        end
        abort = 1'b1; step(); abort = 1'b0;
        check_out("static.abort", 1'b0, 16'h00A5, 1'b0, 1'b0);
        step();
        check_out("static.after", 1'b0, 16'h00A5, 1'b0, 1'b0);

        mode = 2'd3; code_start = 16'h1234; code_end = 16'h2000; dwell = 16'h0000;
        start = 1'b1; abort = 1'b1; step(); start = 1'b0; abort = 1'b0;
        check_out("abort_beats_start", 1'b0, 16'h00A5, 1'b0, 1'b0);
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_out($sformatf("rsvd.c%0d", i), 1'b1, 16'h1234, 1'b1, 1'b0);
            step();
        end
        abort = 1'b1; step(); abort = 1'b0;
        check_out("rsvd.abort", 1'b0, 16'h1234, 1'b0, 1'b0);

        // Mode 2: LFSR walk when built in, otherwise plain STATIC
        mode = 2'd2; code_start = 16'h0000; dwell = 16'h0001;
        start = 1'b1; step(); start = 1'b0;
        lf = 16'h0001;
        for (int i = 0; i < 20; i++) begin
`ifdef NOISE_SEQ_LFSR_EN
            check_out($sformatf("lfsr.c%0d", i), 1'b1, lf, 1'b1, 1'b0);
            lf = {lf[14:0], lf[15] ^ lf[13] ^ lf[12] ^ lf[10]};
`else
            check_out($sformatf("mode2.c%0d", i), 1'b1, 16'h0000, 1'b1, 1'b0);
`endif
            step();
        end
        abort = 1'b1; step(); abort = 1'b0;
        check("mode2.abort.valid", {31'd0, valid}, 32'd0);

        // Asynchronous reset in the middle of a sweep
        mode = 2'd1; code_start = 16'h0040; code_end = 16'h0080; code_step = 16'h0001; dwell = 16'h0002;
        start = 1'b1; step(); start = 1'b0;
        step(); step();
        check_out("pre_reset", 1'b1, 16'h0041, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1 check_out("async_reset", 1'b0, 16'h0000, 1'b0, 1'b0);
        step();
        rst_n = 1'b1;
        step();
        check_out("post_reset", 1'b0, 16'h0000, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
